// File: rtl/mips_pkg.sv
// Shared MIPS ID-stage definitions: opcodes, ALU operation codes and the packed control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_FUNCT = 4'd5;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = ALU_FUNCT; end
      OP_LW: begin
        c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
        c.alu_src = 1'b1; c.alu_op = ALU_ADD;
      end
      OP_SW:   begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
      OP_ADDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
      OP_SLTI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_SLT; end
      OP_ANDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_AND; end
      OP_ORI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_OR; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Destination w conflicts with source a or b; $0 never conflicts.
  function automatic logic reg_match(input logic [4:0] w, input logic [4:0] a,
                                     input logic [4:0] b);
    return (w != 5'd0) && ((w == a) || (w == b));
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file, two combinational read ports with write-through bypass, $0 hardwired to zero.
module register_file
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= 32'h0;
    end else if (we_i && (wa_i != 5'd0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = mem_q[ra1_i];
    rd2_o = mem_q[ra2_i];
    if (ra1_i == 5'd0) begin
      rd1_o = 32'h0;
    end else if (we_i && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end else begin
      rd1_o = mem_q[ra1_i];
    end
    if (ra2_i == 5'd0) begin
      rd2_o = 32'h0;
    end else if (we_i && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end else begin
      rd2_o = mem_q[ra2_i];
    end
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: IF/ID register, decode, early branch/jump resolution, hazard detection, ID/EX register.
// Optional macro ID_PERF_COUNTERS_EN adds saturating stall/flush counters.
module instruction_decode_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC4 = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instructionInput,
  input  logic [31:0] pc4Input,
  input  logic        regWriteInput,
  input  logic [4:0]  writeRegInput,
  input  logic [31:0] writeDataInput,
  input  logic        exRegWriteInput,
  input  logic        exMemReadInput,
  input  logic [4:0]  exWriteRegInput,
  input  logic        memMemReadInput,
  input  logic [4:0]  memWriteRegInput,
  output logic        hazardOutput,
  output logic        branchTakenOutput,
  output logic [31:0] pcBranchOutput,
  output logic        jumpOutput,
  output logic [31:0] pcJumpOutput,
  output logic [9:0]  ctrlOutput,
  output logic [31:0] readData1Output,
  output logic [31:0] readData2Output,
  output logic [31:0] immediateOutput,
  output logic [4:0]  rsOutput,
  output logic [4:0]  rtOutput,
  output logic [4:0]  rdOutput
`ifdef ID_PERF_COUNTERS_EN
  ,
  output logic [31:0] stallCountOutput,
  output logic [31:0] flushCountOutput
`endif
);

  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rd1, rd2, imm_ext;
  logic        is_branch, load_use, branch_hz, hazard, br_taken, jump;
  ctrl_t       ctrl_dec;

  ctrl_t       ctrl_q;
  logic [31:0] rd1_q, rd2_q, imm_q;
  logic [4:0]  rs_q, rt_q, rd_q;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];

  register_file u_register_file (
    .clk_i   (clk),
    .reset_i (reset),
    .ra1_i   (rs),
    .ra2_i   (rt),
    .we_i    (regWriteInput),
    .wa_i    (writeRegInput),
    .wd_i    (writeDataInput),
    .rd1_o   (rd1),
    .rd2_o   (rd2)
  );

  assign ctrl_dec  = decode_ctrl(opcode);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign load_use  = exMemReadInput && reg_match(exWriteRegInput, rs, rt);
  assign branch_hz = is_branch &&
                     ((exRegWriteInput && reg_match(exWriteRegInput, rs, rt)) ||
                      (memMemReadInput && reg_match(memWriteRegInput, rs, rt)));
  assign hazard    = load_use || branch_hz;
  // A stalled branch/jump must not redirect; it resolves once the hazard clears.
  assign br_taken  = !hazard && (((opcode == OP_BEQ) && (rd1 == rd2)) ||
                                 ((opcode == OP_BNE) && (rd1 != rd2)));
  assign jump      = !hazard && (opcode == OP_J);

  always_comb begin
    imm_ext = {{16{instr_q[15]}}, instr_q[15:0]};
    if ((opcode == OP_ANDI) || (opcode == OP_ORI)) begin
      imm_ext = {16'h0000, instr_q[15:0]};
    end else begin
      imm_ext = {{16{instr_q[15]}}, instr_q[15:0]};
    end
  end

  assign hazardOutput      = hazard;
  assign branchTakenOutput = br_taken;
  assign jumpOutput        = jump;
  assign pcBranchOutput    = pc4_q + {imm_ext[29:0], 2'b00};
  assign pcJumpOutput      = {pc4_q[31:28], instr_q[25:0], 2'b00};

  // IF/ID next state: hold on hazard, squash the fetched slot on redirect.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (hazard) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
    end else if (br_taken || jump) begin
      instr_d = 32'h0000_0000;
      pc4_d   = pc4Input;
    end else begin
      instr_d = instructionInput;
      pc4_d   = pc4Input;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 32'h0000_0000;
      pc4_q   <= RESET_PC4;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || hazard) begin
      ctrl_q <= '0;
      rd1_q  <= 32'h0;
      rd2_q  <= 32'h0;
      imm_q  <= 32'h0;
      rs_q   <= 5'd0;
      rt_q   <= 5'd0;
      rd_q   <= 5'd0;
    end else begin
      ctrl_q <= ctrl_dec;
      rd1_q  <= rd1;
      rd2_q  <= rd2;
      imm_q  <= imm_ext;
      rs_q   <= rs;
      rt_q   <= rt;
      rd_q   <= rd;
    end
  end

  assign ctrlOutput      = ctrl_q;
  assign readData1Output = rd1_q;
  assign readData2Output = rd2_q;
  assign immediateOutput = imm_q;
  assign rsOutput        = rs_q;
  assign rtOutput        = rt_q;
  assign rdOutput        = rd_q;

`ifdef ID_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (hazard && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((br_taken || jump) && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stallCountOutput = stall_cnt_q;
  assign flushCountOutput = flush_cnt_q;
`endif

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
- MIPS ID stage, directly downstream of instruction fetch.
- Contains the IF/ID pipeline register, a 32x32 register file, main decoder, early branch/jump resolution and load-use/branch hazard detection.
- Drives the ID/EX pipeline register. Feeds back stall, branch and jump redirect to fetch.

Parameters:
- RESET_PC4, 32'h0000_0000, pc4 value held in IF/ID after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- instructionInput  in  32  instruction from fetch
- pc4Input  in  32  PC+4 from fetch
- regWriteInput/writeRegInput/writeDataInput  in  1/5/32  writeback port
- exRegWriteInput/exMemReadInput/exWriteRegInput  in  1/1/5  EX-stage destination info
- memMemReadInput/memWriteRegInput  in  1/5  MEM-stage load destination
- hazardOutput  out  1  1 = fetch holds PC
- branchTakenOutput/pcBranchOutput  out  1/32  branch redirect
- jumpOutput/pcJumpOutput  out  1/32  jump redirect
- ctrlOutput  out  10  registered: [9]regWrite [8]memRead [7]memWrite [6]memToReg [5]aluSrc [4]regDst [3:0]aluOp
- readData1Output/readData2Output/immediateOutput  out  32 each  registered operands
- rsOutput/rtOutput/rdOutput  out  5 each  registered register fields

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- On reset:
  - IF/ID register: instr = 0 (nop), pc4 = RESET_PC4.
  - All ID/EX outputs = 0.
  - All registers = 0.
- IF/ID register update, in priority order:
  - reset: load reset values.
  - hazardOutput: hold.
  - branchTakenOutput or jumpOutput: flush to nop. This gives a one-cycle penalty.
  - otherwise: load instructionInput and pc4Input.
- Register file:
  - $0 reads 0 and writes to it are ignored.
  - Written on the clk edge when regWriteInput = 1.
  - Reads are combinational with write-through bypass: if the read address equals writeRegInput, the address is nonzero and regWriteInput = 1, the read returns writeDataInput.
- Decode:
  - R-type 0x00: regWrite, regDst, aluOp = 5 (use funct).
  - lw 0x23: regWrite, memRead, memToReg, aluSrc, aluOp = 0.
  - sw 0x2B: memWrite, aluSrc, aluOp = 0.
  - beq 0x04 / bne 0x05: no controls.
  - addi 0x08: aluOp = 0. slti 0x0A: aluOp = 4. andi 0x0C: aluOp = 2. ori 0x0D: aluOp = 3. All four also set regWrite and aluSrc.
  - j 0x02: no controls.
  - Any other opcode: all controls 0.
- Immediate: zero-extended for andi/ori; sign-extended otherwise.
- Redirect targets:
  - pcBranchOutput = pc4 + (signext(imm) << 2). Wraps modulo 2^32.
  - pcJumpOutput = {pc4[31:28], instr[25:0], 2'b00}.
- Branch resolution is combinational: beq taken when rd1 == rd2; bne taken when rd1 != rd2.
- Hazard, combinational:
  - load-use: exMemReadInput, exWriteRegInput != 0, and it matches rs or rt.
  - branch: the instruction is beq/bne and either (exRegWriteInput and exWriteRegInput matches rs/rt) or (memMemReadInput and memWriteRegInput matches rs/rt). Register 0 never matches.
- While hazardOutput = 1:
  - branchTakenOutput = 0 and jumpOutput = 0.
  - ID/EX loads a bubble: all fields 0.
- Simultaneous events:
  - Hazard together with branch/jump: the hazard wins and resolution is retried next cycle.
  - Writeback in the same cycle as a branch compare: the bypassed value is used.

Optional Feature:
- Macro: ID_PERF_COUNTERS_EN.
- When defined:
  - Adds stallCountOutput (32) and flushCountOutput (32).
  - stallCountOutput increments on each hazard cycle; flushCountOutput increments on each taken branch or jump.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: no ports, no counters.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_J);
  - aluOp constants (ALU_ADD=0, SUB=1, AND=2, OR=3, SLT=4, FUNCT=5);
  - a packed control typedef matching ctrlOutput.
- Sub-module register_file: 32x32, two read ports, one write port, with bypass.

Test Plan:
- Reset check: hold reset 2 cycles, release -> all outputs 0, hazardOutput = 0, IF/ID holds nop.
- Write then read: write $5 = 32'h1234_5678, then decode addi $6,$5,-1 -> readData1Output = 32'h1234_5678, immediateOutput = 32'hFFFF_FFFF, ctrlOutput[9,5] = 1.
- Load-use stall: lw $2,0($1) in EX followed by add $3,$2,$4 in ID -> hazardOutput = 1 for exactly 1 cycle, ID/EX bubble, IF/ID held.
- Taken beq: beq $1,$1,+4 with pc4 = 0x100 -> branchTakenOutput = 1, pcBranchOutput = 0x110, next IF/ID = nop.
- Not-taken bne: bne with equal registers -> no redirect, no flush.
- Jump: j 0x0000040 with pc4 = 0x9000_0004 -> pcJumpOutput = 0x9000_0100, next IF/ID flushed.
- Bypass and branch hazard together: writeback $7 and beq $7,$0 in the same cycle -> compare uses the new value. With EX writing $7 instead -> one stall cycle, then the branch resolves.
